dec_stage_hz: RTL and testbench
===============================

// Module: dec_stage_hz
// PURPOSE
//  Parametrised MIPS decode stage: IF/ID register, register file, control decode, branch/jump resolve.
//  Adds a valid bit, load-use stall handshake to IF, taken-branch flush and forwarding from EX/MEM/WB.
//  Adds a saturating stall counter. Sits between fetch and the EX-stage pipeline register.
// PARAMETERS
//  XLEN     32           datapath/PC width
//  NREG     32           architectural registers; RA_W = $clog2(NREG); r0 hard-wired 0
//  CNT_W    16           stall-counter width
// PORTS
//  clk              in   1      clock, rising edge
//  rstn             in   1      asynchronous active-low reset
//  i_DEC_valid      in   1      IF presents a valid instruction
//  i_DEC_pc         in   XLEN   PC of presented instruction
//  i_DEC_inst       in   32     presented instruction
//  o_DEC_stall      out  1      IF must hold PC/inst this cycle
//  i_DEC_exRegWe    in   1      EX instr writes a register
//  i_DEC_exIsLoad   in   1      EX instr is LW
//  i_DEC_exWRA      in   RA_W   EX destination
//  i_DEC_aluOutE    in   XLEN   EX ALU result
//  i_DEC_memRegWe   in   1      MEM instr writes a register
//  i_DEC_memWRA     in   RA_W   MEM destination
//  i_DEC_memData    in   XLEN   MEM result (load data or ALU result)
//  i_DEC_regWe      in   1      WB write enable
//  i_DEC_WRA        in   RA_W   WB destination
//  i_DEC_rstW       in   XLEN   WB data
//  o_DEC_valid      out  1      decoded bundle below is valid
//  o_DEC_ALUop      out  4      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLL,7 SRL,8 LUI
//  o_DEC_regWe/o_DEC_dMemWe/o_DEC_isLoad out 1 each; forced 0 when o_DEC_valid=0
//  o_DEC_WRA        out  RA_W   rd (R-type), rt (I-type), 31 (JAL)
//  o_DEC_num        out  XLEN   imm16 sign-ext (ADDIU/LW/SW) or zero-ext (ANDI/ORI/XORI)
//  o_DEC_rd1/rd2    out  XLEN   forwarded operands
//  o_DEC_brTaken    out  1      redirect fetch; o_DEC_brTarget out XLEN new PC
//  o_DEC_stallCnt   out  CNT_W  cycles stalled since reset, saturating
// BEHAVIOUR
//  - Reset: IF/ID reg (valid,pc,inst)=0, flush flag=0, stallCnt=0; regfile all 0; every output 0.
//  - IF/ID capture each edge unless stall; captured value = {i_DEC_valid & ~flush, pc, inst}.
//  - Latency: instr presented in cycle N -> decoded outputs comb. valid in cycle N+1.
//  - Regfile: written on edge when i_DEC_regWe & WRA!=0; read is write-through (WB same cycle visible).
//  - Hazard: src = rs (all but J/JAL/LUI), rt (R-type, SW, BEQ, BNE). r0 never hazards/forwards.
//  - Stall = IF/ID valid & hazard (see CONFIGURATION). While stall: o_DEC_stall=1, IF/ID holds,
//    o_DEC_valid=0 (bubble to EX), brTaken=0, stallCnt+=1 unless all-ones.
//  - Branch: BEQ/BNE compare forwarded rd1/rd2; target = pc+4+(sext(off)<<2). J/JAL target =
//    {pc+4[XLEN-1:28],idx,2'b00}; JAL rd2 out = pc+8? no: o_DEC_num = pc+4 as link value.
//  - No delay slot: brTaken (valid, no stall) sets flush flag; next captured instr has valid=0;
//    flag clears after that capture. Flush beats i_DEC_valid. Stall and branch same cycle: stall wins.
//  - Unknown opcode/funct: valid passes, all write enables 0 (NOP).
//  - Reset asserted mid-stall or mid-flush: everything returns to reset state immediately.
// CONFIGURATION
//  DEC_FWD_EN defined: operand = EX aluOutE if exRegWe&WRA match & ~exIsLoad, else MEM match
//    memData, else regfile; priority EX>MEM>WB. Stall only when exIsLoad & match (load-use, 1 cycle).
//  DEC_FWD_EN undefined: no forwarding muxes; stall while any src matches EX or MEM destination
//    with RegWe; WB covered by write-through.
// TESTING
//  1 Reset: rstn=0 mid-run -> all outputs 0, stallCnt=0; first inst after release valid at N+1.
//  2 FWD_EN: EX ADDU r3 result 0x11, DEC ADDU r4,r3,r3 -> rd1=rd2=0x11, stall=0.
//  3 FWD_EN: EX LW r5, DEC uses r5 -> stall=1 one cycle, valid=0, stallCnt=1; MEM data 0xAB fwd next.
//  4 No FWD_EN: same as 2 -> stall 2 cycles, then rd1=0x11 from regfile, stallCnt=2.
//  5 BEQ r1,r2,+4 (r1=r2=7) at pc 0x100 -> brTaken=1, target 0x114; next instr valid=0.
//  6 WB write r0=0xFF and DEC reads r0 -> rd1=0; saturate: CNT_W=2, 5 stalls -> stallCnt=3.

Source files
------------

// File: rtl/dec_stage_hz.sv
// dec_stage_hz: MIPS decode stage with IF/ID register, write-through register
// file, control decode, branch/jump resolution, load-use / RAW hazard stall,
// same-edge taken-branch flush, optional EX/MEM forwarding and a saturating
// stall counter. Sits between fetch and the EX-stage pipeline register.
//
// Build option: define DEC_FWD_EN to enable EX/MEM operand forwarding. Then
// only a load in EX whose destination matches a source stalls. Without it,
// any source matching a writing EX or MEM destination stalls, and WB is
// covered by the write-through read.
//
// Ports:
//   clk, rstn                    clock, async active-low reset
//   i_DEC_valid/pc/inst          instruction presented by IF
//   o_DEC_stall                  IF must hold PC/inst this cycle
//   i_DEC_ex*/i_DEC_mem*         EX and MEM destination info and results
//   i_DEC_regWe/WRA/rstW         WB register-file write port
//   o_DEC_valid + bundle         decoded instruction for EX (zero when invalid)
//   o_DEC_brTaken/brTarget       fetch redirect
//   o_DEC_stallCnt               stalled cycles since reset, saturating
module dec_stage_hz #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned RA_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_DEC_valid,
    input  logic [XLEN-1:0]  i_DEC_pc,
    input  logic [31:0]      i_DEC_inst,
    output logic             o_DEC_stall,
    input  logic             i_DEC_exRegWe,
    input  logic             i_DEC_exIsLoad,
    input  logic [RA_W-1:0]  i_DEC_exWRA,
    input  logic [XLEN-1:0]  i_DEC_aluOutE,
    input  logic             i_DEC_memRegWe,
    input  logic [RA_W-1:0]  i_DEC_memWRA,
    input  logic [XLEN-1:0]  i_DEC_memData,
    input  logic             i_DEC_regWe,
    input  logic [RA_W-1:0]  i_DEC_WRA,
    input  logic [XLEN-1:0]  i_DEC_rstW,
    output logic             o_DEC_valid,
    output logic [3:0]       o_DEC_ALUop,
    output logic             o_DEC_regWe,
    output logic             o_DEC_dMemWe,
    output logic             o_DEC_isLoad,
    output logic [RA_W-1:0]  o_DEC_WRA,
    output logic [XLEN-1:0]  o_DEC_num,
    output logic [XLEN-1:0]  o_DEC_rd1,
    output logic [XLEN-1:0]  o_DEC_rd2,
    output logic             o_DEC_brTaken,
    output logic [XLEN-1:0]  o_DEC_brTarget,
    output logic [CNT_W-1:0] o_DEC_stallCnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_LUI = 4'd8;

    // IF/ID register, register file and stall counter state
    logic             ifid_valid;
    logic [XLEN-1:0]  ifid_pc;
    logic [31:0]      ifid_inst;
    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] stall_cnt;

    // Instruction fields
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] imm_zx;
    logic [XLEN-1:0] pc4;

    assign opcode = ifid_inst[31:26];
    assign funct  = ifid_inst[5:0];
    assign rs     = RA_W'(ifid_inst[25:21]);
    assign rt     = RA_W'(ifid_inst[20:16]);
    assign rd     = RA_W'(ifid_inst[15:11]);
    assign shamt  = ifid_inst[10:6];
    assign imm_sx = {{(XLEN-16){ifid_inst[15]}}, ifid_inst[15:0]};
    assign imm_zx = XLEN'(ifid_inst[15:0]);
    assign pc4    = ifid_pc + XLEN'(4);

    // Control decode
    logic            dec_we, dec_mwe, dec_ld;
    logic [3:0]      dec_op;
    logic [RA_W-1:0] dec_wra;
    logic [XLEN-1:0] dec_num;
    logic            use_rs, use_rt, is_beq, is_bne, is_jmp;

    always_comb begin
        dec_we  = 1'b0;
        dec_mwe = 1'b0;
        dec_ld  = 1'b0;
        dec_op  = ALU_ADD;
        dec_wra = rt;
        dec_num = '0;
        use_rs  = 1'b1;
        use_rt  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jmp  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rt  = 1'b1;
                dec_wra = rd;
                dec_we  = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_op = ALU_SUB;
                    FN_AND:          dec_op = ALU_AND;
                    FN_OR:           dec_op = ALU_OR;
                    FN_XOR:          dec_op = ALU_XOR;
                    FN_SLT:          dec_op = ALU_SLT;
                    FN_SLL: begin
                        dec_op  = ALU_SLL;
                        dec_num = XLEN'(shamt);
                    end
                    FN_SRL: begin
                        dec_op  = ALU_SRL;
                        dec_num = XLEN'(shamt);
                    end
                    default: dec_we = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                dec_we  = 1'b1;
                dec_num = imm_sx;
            end
            OP_ANDI: begin
                dec_we  = 1'b1;
                dec_op  = ALU_AND;
                dec_num = imm_zx;
            end
            OP_ORI: begin
                dec_we  = 1'b1;
                dec_op  = ALU_OR;
                dec_num = imm_zx;
            end
            OP_XORI: begin
                dec_we  = 1'b1;
                dec_op  = ALU_XOR;
                dec_num = imm_zx;
            end
            OP_LUI: begin
                use_rs  = 1'b0;
                dec_we  = 1'b1;
                dec_op  = ALU_LUI;
                dec_num = imm_zx;
            end
            OP_LW: begin
                dec_we  = 1'b1;
                dec_ld  = 1'b1;
                dec_num = imm_sx;
            end
            OP_SW: begin
                use_rt  = 1'b1;
                dec_mwe = 1'b1;
                dec_num = imm_sx;
            end
            OP_BEQ: begin
                use_rt = 1'b1;
                is_beq = 1'b1;
                dec_op = ALU_SUB;
            end
            OP_BNE: begin
                use_rt = 1'b1;
                is_bne = 1'b1;
                dec_op = ALU_SUB;
            end
            OP_J: begin
                use_rs = 1'b0;
                is_jmp = 1'b1;
            end
            OP_JAL: begin
                use_rs  = 1'b0;
                is_jmp  = 1'b1;
                dec_we  = 1'b1;
                dec_wra = RA_W'(31);
                dec_num = pc4;
            end
            default: ;
        endcase
    end

    // Operand read (write-through from WB), forwarding and hazard detection
    logic [XLEN-1:0] rf_rs, rf_rt, rd1, rd2;
    logic            ex_rs, ex_rt, mem_rs, mem_rt, haz_rs, haz_rt;

    always_comb begin
        rf_rs = '0;
        rf_rt = '0;
        if (rs != '0) rf_rs = (i_DEC_regWe && i_DEC_WRA == rs) ? i_DEC_rstW : regs[rs];
        if (rt != '0) rf_rt = (i_DEC_regWe && i_DEC_WRA == rt) ? i_DEC_rstW : regs[rt];
        ex_rs  = i_DEC_exRegWe  && (i_DEC_exWRA  == rs) && (rs != '0);
        ex_rt  = i_DEC_exRegWe  && (i_DEC_exWRA  == rt) && (rt != '0);
        mem_rs = i_DEC_memRegWe && (i_DEC_memWRA == rs) && (rs != '0);
        mem_rt = i_DEC_memRegWe && (i_DEC_memWRA == rt) && (rt != '0);
`ifdef DEC_FWD_EN
        haz_rs = use_rs && ex_rs && i_DEC_exIsLoad;
        haz_rt = use_rt && ex_rt && i_DEC_exIsLoad;
        rd1 = (ex_rs && !i_DEC_exIsLoad) ? i_DEC_aluOutE : (mem_rs ? i_DEC_memData : rf_rs);
        rd2 = (ex_rt && !i_DEC_exIsLoad) ? i_DEC_aluOutE : (mem_rt ? i_DEC_memData : rf_rt);
`else
        haz_rs = use_rs && (ex_rs || mem_rs);
        haz_rt = use_rt && (ex_rt || mem_rt);
        rd1 = rf_rs;
        rd2 = rf_rt;
`endif
    end

`ifndef DEC_FWD_EN
    // Forwarding inputs are not consumed in this build
    logic unused_fwd;
    assign unused_fwd = ^{i_DEC_aluOutE, i_DEC_memData, i_DEC_exIsLoad};
`endif

    // Stall, bubble and branch resolution; stall suppresses the redirect
    logic            stall_c, out_valid, br_c;
    logic [XLEN-1:0] tgt_c;

    assign stall_c   = ifid_valid && (haz_rs || haz_rt);
    assign out_valid = ifid_valid && !stall_c;
    assign br_c      = out_valid && (is_jmp || (is_beq && (rd1 == rd2)) || (is_bne && (rd1 != rd2)));
    assign tgt_c     = is_jmp ? {pc4[XLEN-1:28], ifid_inst[25:0], 2'b00}
                              : pc4 + (imm_sx << 2);

    // The wrong-path instruction is the one captured on the redirect edge, so it is killed there
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_inst  <= '0;
        end else if (!stall_c) begin
            ifid_valid <= i_DEC_valid && !br_c;
            ifid_pc    <= i_DEC_pc;
            ifid_inst  <= i_DEC_inst;
        end
    end

    // Register file; r0 is never written
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (i_DEC_regWe && i_DEC_WRA != '0) begin
            regs[i_DEC_WRA] <= i_DEC_rstW;
        end
    end

    // Saturating stall counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall_c && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign o_DEC_stall    = stall_c;
    assign o_DEC_valid    = out_valid;
    assign o_DEC_ALUop    = out_valid ? dec_op  : 4'd0;
    assign o_DEC_regWe    = out_valid && dec_we;
    assign o_DEC_dMemWe   = out_valid && dec_mwe;
    assign o_DEC_isLoad   = out_valid && dec_ld;
    assign o_DEC_WRA      = out_valid ? dec_wra : '0;
    assign o_DEC_num      = out_valid ? dec_num : '0;
    assign o_DEC_rd1      = out_valid ? rd1     : '0;
    assign o_DEC_rd2      = out_valid ? rd2     : '0;
    assign o_DEC_brTaken  = br_c;
    assign o_DEC_brTarget = out_valid ? tgt_c   : '0;
    assign o_DEC_stallCnt = stall_cnt;

endmodule

// File: tb/tb_dec_stage_hz.sv
// Scoreboard bench for dec_stage_hz: expectations are queued as stimulus is
// driven and drained mid-cycle. A second instance with a 2-bit stall counter
// shares all inputs to exercise counter saturation.
module tb_dec_stage_hz;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    localparam int S_VALID = 0, S_STALL = 1, S_RD1 = 2, S_RD2 = 3, S_BR = 4, S_TGT = 5,
                   S_CNT = 6, S_CNT2 = 7, S_WE = 8, S_MWE = 9, S_LD = 10, S_WRA = 11,
                   S_NUM = 12, S_OP = 13;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic            i_valid = 0;
    logic [XLEN-1:0] i_pc = 0;
    logic [31:0]     i_inst = 0;
    logic            ex_we = 0, ex_ld = 0;
    logic [RA_W-1:0] ex_wra = 0;
    logic [XLEN-1:0] ex_d = 0;
    logic            mem_we = 0;
    logic [RA_W-1:0] mem_wra = 0;
    logic [XLEN-1:0] mem_d = 0;
    logic            wb_we = 0;
    logic [RA_W-1:0] wb_wra = 0;
    logic [XLEN-1:0] wb_d = 0;

    logic            stall, valid, we, mwe, ld, br;
    logic [3:0]      aluop;
    logic [RA_W-1:0] wra;
    logic [XLEN-1:0] num, rd1, rd2, tgt;
    logic [15:0]     cnt;

    logic            stall_b, valid_b, we_b, mwe_b, ld_b, br_b;
    logic [3:0]      aluop_b;
    logic [RA_W-1:0] wra_b;
    logic [XLEN-1:0] num_b, rd1_b, rd2_b, tgt_b;
    logic [1:0]      cnt_b;

    dec_stage_hz dut (
        .clk(clk), .rstn(rstn),
        .i_DEC_valid(i_valid), .i_DEC_pc(i_pc), .i_DEC_inst(i_inst), .o_DEC_stall(stall),
        .i_DEC_exRegWe(ex_we), .i_DEC_exIsLoad(ex_ld), .i_DEC_exWRA(ex_wra), .i_DEC_aluOutE(ex_d),
        .i_DEC_memRegWe(mem_we), .i_DEC_memWRA(mem_wra), .i_DEC_memData(mem_d),
        .i_DEC_regWe(wb_we), .i_DEC_WRA(wb_wra), .i_DEC_rstW(wb_d),
        .o_DEC_valid(valid), .o_DEC_ALUop(aluop), .o_DEC_regWe(we), .o_DEC_dMemWe(mwe),
        .o_DEC_isLoad(ld), .o_DEC_WRA(wra), .o_DEC_num(num), .o_DEC_rd1(rd1), .o_DEC_rd2(rd2),
        .o_DEC_brTaken(br), .o_DEC_brTarget(tgt), .o_DEC_stallCnt(cnt)
    );

    dec_stage_hz #(.CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn),
        .i_DEC_valid(i_valid), .i_DEC_pc(i_pc), .i_DEC_inst(i_inst), .o_DEC_stall(stall_b),
        .i_DEC_exRegWe(ex_we), .i_DEC_exIsLoad(ex_ld), .i_DEC_exWRA(ex_wra), .i_DEC_aluOutE(ex_d),
        .i_DEC_memRegWe(mem_we), .i_DEC_memWRA(mem_wra), .i_DEC_memData(mem_d),
        .i_DEC_regWe(wb_we), .i_DEC_WRA(wb_wra), .i_DEC_rstW(wb_d),
        .o_DEC_valid(valid_b), .o_DEC_ALUop(aluop_b), .o_DEC_regWe(we_b), .o_DEC_dMemWe(mwe_b),
        .o_DEC_isLoad(ld_b), .o_DEC_WRA(wra_b), .o_DEC_num(num_b), .o_DEC_rd1(rd1_b),
        .o_DEC_rd2(rd2_b), .o_DEC_brTaken(br_b), .o_DEC_brTarget(tgt_b), .o_DEC_stallCnt(cnt_b)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_VALID: return 32'(valid);
            S_STALL: return 32'(stall);
            S_RD1:   return rd1;
            S_RD2:   return rd2;
            S_BR:    return 32'(br);
            S_TGT:   return tgt;
            S_CNT:   return 32'(cnt);
            S_CNT2:  return 32'(cnt_b);
            S_WE:    return 32'(we);
            S_MWE:   return 32'(mwe);
            S_LD:    return 32'(ld);
            S_WRA:   return 32'(wra);
            S_NUM:   return num;
            default: return 32'(aluop);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    // Check one cycle mid-period, then advance to just after the next rising edge
    task automatic tick(input bit st);
        exp_t e;
        push("stall", S_STALL, 32'(st));
        push("stall_cnt", S_CNT, 32'(exp_cnt));
        push("stall_cnt_sat", S_CNT2, 32'((exp_cnt > 3) ? 3 : exp_cnt));
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
        @(posedge clk);
        #1;
        if (st) exp_cnt++;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        i_valid = v; i_pc = pc; i_inst = inst;
    endtask
    task automatic set_ex(input logic w, input logic l, input int a, input logic [31:0] d);
        ex_we = w; ex_ld = l; ex_wra = RA_W'(a); ex_d = d;
    endtask
    task automatic set_mem(input logic w, input int a, input logic [31:0] d);
        mem_we = w; mem_wra = RA_W'(a); mem_d = d;
    endtask
    task automatic set_wb(input logic w, input int a, input logic [31:0] d);
        wb_we = w; wb_wra = RA_W'(a); wb_d = d;
    endtask

    function automatic logic [31:0] r_type(input int rs_i, input int rt_i, input int rd_i, input logic [5:0] fn);
        return {6'h00, 5'(rs_i), 5'(rt_i), 5'(rd_i), 5'd0, fn};
    endfunction
    function automatic logic [31:0] i_type(input logic [5:0] op, input int rs_i, input int rt_i, input logic [15:0] imm);
        return {op, 5'(rs_i), 5'(rt_i), imm};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        push("rst_valid", S_VALID, 0); push("rst_rd1", S_RD1, 0); push("rst_br", S_BR, 0);
        push("rst_tgt", S_TGT, 0); push("rst_num", S_NUM, 0);
        tick(0);
        rstn = 1'b1;

        // Load r1=r2=7; r0 write must be ignored
        set_wb(1, 1, 7); push("empty_valid", S_VALID, 0); tick(0);
        set_wb(1, 2, 7); tick(0);
        set_wb(1, 0, 32'hFF); set_if(1, 32'h100, i_type(6'h04, 1, 2, 16'd4));
        push("empty_valid2", S_VALID, 0); tick(0);

        // BEQ taken, wrong-path instruction killed
        set_wb(0, 0, 0); set_if(1, 32'h104, i_type(6'h09, 0, 9, 16'd1));
        push("beq_valid", S_VALID, 1); push("beq_br", S_BR, 1); push("beq_tgt", S_TGT, 32'h114);
        push("beq_rd1", S_RD1, 7); push("beq_rd2", S_RD2, 7); push("beq_we", S_WE, 0);
        tick(0);
        set_if(1, 32'h114, r_type(0, 1, 6, 6'h21));
        push("flush_valid", S_VALID, 0); push("flush_br", S_BR, 0); push("flush_we", S_WE, 0);
        tick(0);

        // r0 read is zero and never matches an EX destination of r0
        set_ex(1, 0, 0, 32'h55); set_if(1, 32'h118, r_type(3, 3, 4, 6'h21));
        push("r0_valid", S_VALID, 1); push("r0_rd1", S_RD1, 0); push("r0_rd2", S_RD2, 7);
        push("addu_we", S_WE, 1); push("addu_wra", S_WRA, 6); push("addu_op", S_OP, 0);
        tick(0);

        // ADDU r4,r3,r3 with producer of r3 moving EX->MEM->WB
        set_if(0, 0, 0); set_ex(1, 0, 3, 32'h11);
`ifdef DEC_FWD_EN
        push("fwd_ex_valid", S_VALID, 1); push("fwd_ex_rd1", S_RD1, 32'h11);
        push("fwd_ex_rd2", S_RD2, 32'h11); push("fwd_ex_wra", S_WRA, 4);
        tick(0);
        set_ex(0, 0, 0, 0); set_mem(1, 3, 32'h11); push("bubble_valid", S_VALID, 0); tick(0);
        set_mem(0, 0, 0); set_wb(1, 3, 32'h11); tick(0);
`else
        push("raw_ex_valid", S_VALID, 0); push("raw_ex_we", S_WE, 0); tick(1);
        set_ex(0, 0, 0, 0); set_mem(1, 3, 32'h11); push("raw_mem_valid", S_VALID, 0); tick(1);
        set_mem(0, 0, 0); set_wb(1, 3, 32'h11);
        push("raw_wb_valid", S_VALID, 1); push("raw_wb_rd1", S_RD1, 32'h11);
        push("raw_wb_rd2", S_RD2, 32'h11); push("raw_wb_wra", S_WRA, 4);
        tick(0);
`endif
        set_wb(0, 0, 0);

        // Load-use on r5: ADDU r7,r5,r0 behind LW r5
        set_if(1, 32'h200, r_type(5, 0, 7, 6'h21)); tick(0);
        set_if(0, 0, 0); set_ex(1, 1, 5, 32'hDEAD); push("lu_valid", S_VALID, 0); tick(1);
`ifdef DEC_FWD_EN
        set_ex(0, 0, 0, 0); set_mem(1, 5, 32'hAB);
        push("lu_mem_valid", S_VALID, 1); push("lu_mem_rd1", S_RD1, 32'hAB); push("lu_mem_rd2", S_RD2, 0);
        tick(0);
        set_mem(0, 0, 0); set_wb(1, 5, 32'hAB); tick(0);
`else
        set_ex(0, 0, 0, 0); set_mem(1, 5, 32'hAB); push("lu_mem_valid", S_VALID, 0); tick(1);
        set_mem(0, 0, 0); set_wb(1, 5, 32'hAB);
        push("lu_wb_valid", S_VALID, 1); push("lu_wb_rd1", S_RD1, 32'hAB); push("lu_wb_rd2", S_RD2, 0);
        tick(0);
`endif
        set_wb(0, 0, 0);

`ifdef DEC_FWD_EN
        // Forwarding priority EX > MEM > WB, then MEM > WB
        set_if(1, 32'h300, r_type(8, 8, 9, 6'h21)); tick(0);
        set_if(1, 32'h304, r_type(10, 0, 9, 6'h21));
        set_ex(1, 0, 8, 32'h22); set_mem(1, 8, 32'h33); set_wb(1, 8, 32'h44);
        push("prio_ex_rd1", S_RD1, 32'h22); push("prio_ex_rd2", S_RD2, 32'h22); push("prio_ex_valid", S_VALID, 1);
        tick(0);
        set_if(0, 0, 0); set_ex(0, 0, 0, 0); set_mem(1, 10, 32'h33); set_wb(1, 10, 32'h44);
        push("prio_mem_rd1", S_RD1, 32'h33); push("prio_mem_valid", S_VALID, 1);
        tick(0);
        set_mem(0, 0, 0); set_wb(0, 0, 0);
`endif

        // Long load-use stall drives the 2-bit counter into saturation
        set_if(1, 32'h500, r_type(13, 0, 12, 6'h21)); tick(0);
        set_if(0, 0, 0); set_ex(1, 1, 13, 0);
        for (int k = 0; k < 5; k++) begin
            push("sat_valid", S_VALID, 0);
            tick(1);
        end
        set_ex(0, 0, 0, 0);
        push("sat_rel_valid", S_VALID, 1); push("sat_rel_rd1", S_RD1, 0);
        tick(0);

        // Reset asserted mid-stall
        set_if(1, 32'h600, r_type(13, 0, 12, 6'h21)); tick(0);
        set_if(0, 0, 0); set_ex(1, 1, 13, 0); push("pre_rst_valid", S_VALID, 0); tick(1);
        rstn = 1'b0;
        exp_cnt = 0;
        push("mid_rst_valid", S_VALID, 0); push("mid_rst_rd1", S_RD1, 0); push("mid_rst_br", S_BR, 0);
        push("mid_rst_tgt", S_TGT, 0); push("mid_rst_num", S_NUM, 0); push("mid_rst_we", S_WE, 0);
        tick(0);
        rstn = 1'b1;
        set_ex(0, 0, 0, 0);

        // First instruction after release is valid one cycle later
        set_if(1, 32'h700, i_type(6'h09, 0, 11, 16'hFFFF));
        push("post_rst_valid", S_VALID, 0); tick(0);
        set_if(1, 32'h704, i_type(6'h0d, 0, 12, 16'h8000));
        push("addiu_valid", S_VALID, 1); push("addiu_num", S_NUM, 32'hFFFF_FFFF);
        push("addiu_wra", S_WRA, 11); push("addiu_we", S_WE, 1); push("addiu_op", S_OP, 0);
        tick(0);
        set_if(1, 32'h708, i_type(6'h2b, 2, 1, 16'd4));
        push("ori_num", S_NUM, 32'h0000_8000); push("ori_op", S_OP, 3); push("ori_wra", S_WRA, 12);
        tick(0);
        set_if(1, 32'h70C, i_type(6'h05, 1, 2, 16'd8));
        push("sw_we", S_WE, 0); push("sw_mwe", S_MWE, 1); push("sw_ld", S_LD, 0); push("sw_num", S_NUM, 4);
        tick(0);
        set_if(1, 32'h710, {6'h03, 26'h40});
        push("bne_br", S_BR, 0); push("bne_valid", S_VALID, 1); push("bne_we", S_WE, 0);
        tick(0);
        set_if(1, 32'h714, 32'hFC00_0000);
        push("jal_br", S_BR, 1); push("jal_tgt", S_TGT, 32'h100); push("jal_num", S_NUM, 32'h714);
        push("jal_wra", S_WRA, 31); push("jal_we", S_WE, 1);
        tick(0);
        set_if(1, 32'h100, 32'hFC00_0000);
        push("jal_flush_valid", S_VALID, 0); tick(0);
        set_if(1, 32'h104, i_type(6'h23, 0, 14, 16'd0));
        push("unk_valid", S_VALID, 1); push("unk_we", S_WE, 0); push("unk_mwe", S_MWE, 0);
        push("unk_br", S_BR, 0);
        tick(0);
        set_if(0, 0, 0);
        push("lw_ld", S_LD, 1); push("lw_we", S_WE, 1); push("lw_wra", S_WRA, 14);
        tick(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
